// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/loader memory-port arbiter.
// Holds the default bus widths, the arbiter state encodings, the owner tags
// and a helper for sizing the burst counter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_F  = 2'd1,
    ST_OWN_L  = 2'd2,
    ST_LOCKED = 2'd3
  } arb_state_t;

  // Tag carried down the access pipeline so read data reaches the right port.
  typedef enum logic {
    OWN_F = 1'b0,
    OWN_L = 1'b1
  } owner_t;

  // Counter must be able to hold MAX_BURST itself (saturation value).
  function automatic int burst_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_burst_ctr.sv
// Purpose: saturating count of consecutive transfers by the current owner.
// Latency: count updates on the clock edge; limit flag is decoded from the registered count.
// Backpressure: none; the arbiter uses the limit flag to hand the port over.
//
// Ports:
//   clk, rst   clock / synchronous active-high reset (count -> 0)
//   clr        force count to 0 (idle or locked)
//   load1      new owner's first transfer: count -> 1
//   inc        another transfer by the same owner: count + 1, held at MAX_BURST
//   at_limit   count has reached MAX_BURST
module arb_burst_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load1,
  input  logic inc,
  output logic at_limit
);

  localparam int BW = burst_w(MAX_BURST);
  localparam logic [BW-1:0] LIMIT = BW'(MAX_BURST);

  logic [BW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= BW'(1);
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + BW'(1);
    end
  end

  assign at_limit = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port synchronous RAM between CPU fetch (F, read-only) and loader (L, read/write).
// Latency: grant combinational; access strobe one cycle after the transfer edge, read data two cycles after.
// Backpressure: req/gnt handshake; a waiting port gets the memory after at most MAX_BURST owner transfers,
//               while l_lock holds fetch off entirely.
//
// Ports:
//   clk, rst                         clock / synchronous active-high reset
//   f_req, f_addr                    fetch read request and address
//   f_gnt, f_rvalid, f_rdata         fetch accept, read data valid, read data (0 when not valid)
//   l_req, l_we, l_addr, l_wdata     loader request, write enable, address, write data
//   l_lock                           loader asks for exclusive ownership
//   l_gnt, l_rvalid, l_rdata         loader accept, read data valid, read data (0 when not valid)
//   locked                           arbiter is in the locked state
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata             memory macro interface (read data valid the cycle after mem_en)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  parameter bit PRIO_F    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state;
  owner_t     acc_owner;
  logic       at_limit;
  logic       f_xfer, l_xfer, any_xfer;
  logic       same_owner;
  logic       ctr_clr, ctr_load1, ctr_inc;

  // Grant decode. Held at zero during reset so nothing is accepted in the reset cycle.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!rst) begin
      if (state == ST_LOCKED) begin
        l_gnt = l_req;
      end else if (f_req && l_req) begin
        case (state)
          ST_OWN_F: begin
            if (at_limit) l_gnt = 1'b1;
            else          f_gnt = 1'b1;
          end
          ST_OWN_L: begin
            if (at_limit) f_gnt = 1'b1;
            else          l_gnt = 1'b1;
          end
          default: begin
            if (PRIO_F) f_gnt = 1'b1;
            else        l_gnt = 1'b1;
          end
        endcase
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
    end
  end

  assign f_xfer   = f_req && f_gnt;
  assign l_xfer   = l_req && l_gnt;
  assign any_xfer = f_xfer || l_xfer;

  assign same_owner = (f_xfer && (state == ST_OWN_F)) ||
                      (l_xfer && (state == ST_OWN_L));

  // Burst count is meaningless while locked and restarts from zero on unlock,
  // so entering, staying in or leaving LOCKED all clear it.
  assign ctr_clr   = l_lock || (state == ST_LOCKED) || (!any_xfer && !f_req && !l_req);
  assign ctr_load1 = any_xfer && !same_owner;
  assign ctr_inc   = any_xfer && same_owner;

  arb_burst_ctr #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .load1    (ctr_load1),
    .inc      (ctr_inc),
    .at_limit (at_limit)
  );

  // Ownership FSM. Lock wins over any transfer at the same edge; that transfer
  // still enters the access pipeline below and completes normally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      locked <= 1'b0;
    end else begin
      locked <= l_lock;
      if (l_lock) begin
        state <= ST_LOCKED;
      end else if (state == ST_LOCKED) begin
        state <= ST_IDLE;
      end else if (f_xfer) begin
        state <= ST_OWN_F;
      end else if (l_xfer) begin
        state <= ST_OWN_L;
      end else if (!f_req && !l_req) begin
        state <= ST_IDLE;
      end
    end
  end

  // Access stage followed by the read-return stage. The owner tag travels with
  // the access so back-to-back reads from alternating ports return correctly.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      acc_owner <= OWN_F;
      f_rvalid  <= 1'b0;
      l_rvalid  <= 1'b0;
    end else begin
      mem_en <= any_xfer;
      mem_we <= l_xfer && l_we;
      if (any_xfer) begin
        mem_addr  <= f_xfer ? f_addr : l_addr;
        mem_wdata <= l_xfer ? l_wdata : '0;
        acc_owner <= f_xfer ? OWN_F : OWN_L;
      end
      f_rvalid <= mem_en && !mem_we && (acc_owner == OWN_F);
      l_rvalid <= mem_en && !mem_we && (acc_owner == OWN_L);
    end
  end

  assign f_rdata = f_rvalid ? mem_rdata : '0;
  assign l_rdata = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, expected read data pushed into
// per-port queues and popped by an independent monitor when rvalid appears.
// Memory model preload: mem[a] = a ^ 8'hB5.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic       f_req;
  logic [7:0] f_addr;
  logic       f_gnt;
  logic       f_rvalid;
  logic [7:0] f_rdata;
  logic       l_req;
  logic       l_we;
  logic [7:0] l_addr;
  logic [7:0] l_wdata;
  logic       l_lock;
  logic       l_gnt;
  logic       l_rvalid;
  logic [7:0] l_rdata;
  logic       locked;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks;
  int failures;
  int en_cnt;
  int we_cnt;

  logic [7:0] fq[$];
  logic [7:0] lq[$];
  logic [7:0] mem[256];
  logic [7:0] fe, le;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .locked    (locked),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data registered on the edge that ends the mem_en cycle.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hB5;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: access strobes counted, read data compared against the scoreboard.
  initial begin
    en_cnt = 0;
    we_cnt = 0;
  end
  always @(negedge clk) begin
    if (mem_en === 1'b1) en_cnt++;
    if (mem_en === 1'b1 && mem_we === 1'b1) we_cnt++;

    if (f_rvalid === 1'b1) begin
      if (fq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL f_unexpected_rvalid actual=%0h required=no_rvalid", f_rdata);
      end else begin
        fe = fq.pop_front();
        chk("f_rdata", 32'(f_rdata), 32'(fe));
      end
    end else begin
      chk("f_rdata_idle_zero", 32'(f_rdata), 32'h0);
    end

    if (l_rvalid === 1'b1) begin
      if (lq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL l_unexpected_rvalid actual=%0h required=no_rvalid", l_rdata);
      end else begin
        le = lq.pop_front();
        chk("l_rdata", 32'(l_rdata), 32'(le));
      end
    end else begin
      chk("l_rdata_idle_zero", 32'(l_rdata), 32'h0);
    end
  end

  // Contention grant pattern from IDLE with MAX_BURST=4, PRIO_F=1 (1 = F granted).
  bit exp_pat[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int snap;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    f_req    = 1'b1;
    f_addr   = 8'h10;
    l_req    = 1'b0;
    l_we     = 1'b0;
    l_addr   = 8'h00;
    l_wdata  = 8'h00;
    l_lock   = 1'b0;

    // ---- reset: no grant in the reset cycle, outputs cleared ----
    step();
    sample();
    chk("rst_f_gnt", 32'(f_gnt), 32'h0);
    chk("rst_l_gnt", 32'(l_gnt), 32'h0);
    step();
    rst   = 1'b0;
    f_req = 1'b0;
    sample();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_f_rvalid", 32'(f_rvalid), 32'h0);
    chk("rst_l_rvalid", 32'(l_rvalid), 32'h0);

    // ---- solo fetch 0x10 -> 0xA5 ----
    step();
    f_req  = 1'b1;
    f_addr = 8'h10;
    sample();
    chk("solo_f_gnt", 32'(f_gnt), 32'h1);
    chk("solo_l_gnt", 32'(l_gnt), 32'h0);
    fq.push_back(8'hA5);
    step();
    f_req = 1'b0;
    sample();
    chk("solo_mem_en", 32'(mem_en), 32'h1);
    chk("solo_mem_addr", 32'(mem_addr), 32'h10);
    chk("solo_mem_we", 32'(mem_we), 32'h0);
    chk("solo_rvalid_early", 32'(f_rvalid), 32'h0);
    step();
    sample();
    chk("solo_f_rvalid", 32'(f_rvalid), 32'h1);
    chk("solo_mem_en_off", 32'(mem_en), 32'h0);
    step();

    // ---- contention from IDLE: F,F,F,F,L,L,L,L,F,F ----
    f_req  = 1'b1;
    f_addr = 8'h20;
    l_req  = 1'b1;
    l_we   = 1'b0;
    l_addr = 8'h40;
    for (int k = 0; k < 10; k++) begin
      sample();
      chk("cont_f_gnt", 32'(f_gnt), 32'(exp_pat[k]));
      chk("cont_l_gnt", 32'(l_gnt), 32'(!exp_pat[k]));
      if (exp_pat[k]) fq.push_back(8'h95);
      else            lq.push_back(8'hF5);
      step();
    end
    f_req = 1'b0;
    l_req = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // ---- loader write 0x3C=0x5A then read back ----
    snap    = we_cnt;
    l_req   = 1'b1;
    l_we    = 1'b1;
    l_addr  = 8'h3C;
    l_wdata = 8'h5A;
    sample();
    chk("wr_l_gnt", 32'(l_gnt), 32'h1);
    step();
    l_we = 1'b0;
    sample();
    chk("wr_mem_en", 32'(mem_en), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h3C);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
    chk("rd_l_gnt", 32'(l_gnt), 32'h1);
    lq.push_back(8'h5A);
    step();
    l_req = 1'b0;
    sample();
    chk("rd_mem_we", 32'(mem_we), 32'h0);
    chk("rd_mem_en", 32'(mem_en), 32'h1);
    for (int k = 0; k < 4; k++) step();
    chk("wr_once", 32'(we_cnt - snap), 32'h1);

    // ---- lock while fetch bursts ----
    f_req  = 1'b1;
    f_addr = 8'h30;
    sample();
    chk("lk_f_gnt0", 32'(f_gnt), 32'h1);
    fq.push_back(8'h85);
    step();
    sample();
    chk("lk_f_gnt1", 32'(f_gnt), 32'h1);
    fq.push_back(8'h85);
    step();
    l_lock = 1'b1;
    sample();
    chk("lk_f_gnt_at_lock", 32'(f_gnt), 32'h1);
    chk("lk_locked_pre", 32'(locked), 32'h0);
    fq.push_back(8'h85);
    step();
    sample();
    chk("lk_locked", 32'(locked), 32'h1);
    chk("lk_f_blocked", 32'(f_gnt), 32'h0);
    step();
    l_req  = 1'b1;
    l_we   = 1'b0;
    l_addr = 8'h50;
    sample();
    chk("lk_f_blocked2", 32'(f_gnt), 32'h0);
    chk("lk_l_gnt", 32'(l_gnt), 32'h1);
    chk("lk_locked2", 32'(locked), 32'h1);
    lq.push_back(8'hE5);
    step();
    l_req = 1'b0;
    sample();
    chk("lk_f_blocked3", 32'(f_gnt), 32'h0);
    step();
    l_lock = 1'b0;
    sample();
    chk("lk_still_locked", 32'(locked), 32'h1);
    chk("lk_f_blocked4", 32'(f_gnt), 32'h0);
    step();
    sample();
    chk("unlk_locked", 32'(locked), 32'h0);
    chk("unlk_f_gnt", 32'(f_gnt), 32'h1);
    fq.push_back(8'h85);
    step();
    f_req = 1'b0;
    for (int k = 0; k < 4; k++) step();

    // ---- abort: fetch requests for 2 cycles while L owns below limit ----
    snap   = en_cnt;
    l_req  = 1'b1;
    l_we   = 1'b0;
    l_addr = 8'h60;
    sample();
    chk("ab_l_gnt0", 32'(l_gnt), 32'h1);
    lq.push_back(8'hD5);
    step();
    f_req  = 1'b1;
    f_addr = 8'h70;
    sample();
    chk("ab_f_gnt0", 32'(f_gnt), 32'h0);
    chk("ab_l_gnt1", 32'(l_gnt), 32'h1);
    lq.push_back(8'hD5);
    step();
    sample();
    chk("ab_f_gnt1", 32'(f_gnt), 32'h0);
    chk("ab_l_gnt2", 32'(l_gnt), 32'h1);
    lq.push_back(8'hD5);
    step();
    f_req = 1'b0;
    l_req = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("ab_mem_en_count", 32'(en_cnt - snap), 32'h3);

    // ---- reset mid-read: in-flight read dropped ----
    f_req  = 1'b1;
    f_addr = 8'h10;
    sample();
    chk("mr_f_gnt", 32'(f_gnt), 32'h1);
    step();
    rst = 1'b1;
    sample();
    chk("mr_mem_en", 32'(mem_en), 32'h1);
    chk("mr_f_gnt_in_rst", 32'(f_gnt), 32'h0);
    step();
    rst   = 1'b0;
    f_req = 1'b0;
    sample();
    chk("mr_f_rvalid", 32'(f_rvalid), 32'h0);
    chk("mr_l_rvalid", 32'(l_rvalid), 32'h0);
    chk("mr_mem_en_off", 32'(mem_en), 32'h0);
    chk("mr_locked", 32'(locked), 32'h0);
    step();
    f_req = 1'b1;
    l_req = 1'b1;
    sample();
    chk("mr_idle_prio_f", 32'(f_gnt), 32'h1);
    fq.push_back(8'hA5);
    step();
    f_req = 1'b0;
    l_req = 1'b0;
    for (int k = 0; k < 4; k++) step();

    chk("f_queue_drained", 32'(fq.size()), 32'h0);
    chk("l_queue_drained", 32'(lq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
